traffic_intersection_ctrl: RTL and testbench

//  Two-road (North-South / East-West) intersection sequencer; successor to the single-light RED/GREEN/YELLOW cycler.

---
 rtl/tl_pkg.sv | 32 +++
 rtl/tl_phase_timer.sv | 35 +++
 rtl/traffic_intersection_ctrl.sv | 144 ++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and lamp encodings for the two-road intersection sequencer.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED   = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_PED_WALK  = 3'd5,
    PH_FLASH     = 3'd6
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase duration counter: counts enabled ticks up to last_cnt, pulses done on the
// final tick and restarts from zero; clear forces a fresh start.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             clear,
  input  logic [CNT_W-1:0] last_cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    done  = tick_en && (cnt_q == last_cnt);
    cnt_d = cnt_q;
    if (clear || done) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// NS/EW intersection sequencer with all-red clearance, latched pedestrian walk
// and flashing-yellow fail-safe; lamp outputs are a Moore decode of the phase.
module traffic_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 8,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending
);

  localparam int MAX_LEN = max5(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC, FLASH_HALF);

  if (MAX_LEN - 1 >= (1 << CNT_W)) begin : g_cnt_w_too_small
    $error("traffic_intersection_ctrl: CNT_W=%0d cannot hold %0d", CNT_W, MAX_LEN - 1);
  end
  if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 || WALK_CYC < 1 || FLASH_HALF < 1)
  begin : g_len_zero
    $error("traffic_intersection_ctrl: every phase length must be at least 1");
  end

  phase_e           phase_q, phase_d;
  logic             next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             flash_ph_q, flash_ph_d;
  logic             timer_clear;
  logic             timer_done;
  logic [CNT_W-1:0] last_cnt;

  always_comb begin
    case (phase_q)
      PH_NS_GREEN, PH_EW_GREEN:   last_cnt = CNT_W'(GREEN_CYC - 1);
      PH_NS_YELLOW, PH_EW_YELLOW: last_cnt = CNT_W'(YELLOW_CYC - 1);
      PH_PED_WALK:                last_cnt = CNT_W'(WALK_CYC - 1);
      PH_FLASH:                   last_cnt = CNT_W'(FLASH_HALF - 1);
      default:                    last_cnt = CNT_W'(ALLRED_CYC - 1);
    endcase
  end

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .clear    (timer_clear),
    .last_cnt (last_cnt),
    .done     (timer_done)
  );

  // Flash request overrides expiry; a button press in the walk-entry cycle re-latches.
  always_comb begin
    phase_d       = phase_q;
    next_dir_d    = next_dir_q;
    flash_ph_d    = flash_ph_q;
    timer_clear   = 1'b0;
    ped_pending_d = ped_pending_q | ped_req;
    if (flash_mode) begin
      if (phase_q != PH_FLASH) begin
        phase_d     = PH_FLASH;
        flash_ph_d  = 1'b1;
        timer_clear = 1'b1;
      end else if (timer_done) begin
        flash_ph_d = ~flash_ph_q;
      end
    end else if (phase_q == PH_FLASH) begin
      phase_d     = PH_ALL_RED;
      next_dir_d  = DIR_NS;
      timer_clear = 1'b1;
    end else if (timer_done) begin
      case (phase_q)
        PH_NS_GREEN:  phase_d = PH_NS_YELLOW;
        PH_NS_YELLOW: begin
          phase_d    = PH_ALL_RED;
          next_dir_d = DIR_EW;
        end
        PH_EW_GREEN:  phase_d = PH_EW_YELLOW;
        PH_EW_YELLOW: begin
          phase_d    = PH_ALL_RED;
          next_dir_d = DIR_NS;
        end
        PH_PED_WALK:  phase_d = PH_ALL_RED;
        PH_ALL_RED: begin
          if (ped_pending_q) begin
            phase_d       = PH_PED_WALK;
            ped_pending_d = ped_req;
          end else if (next_dir_q == DIR_NS) begin
            phase_d = PH_NS_GREEN;
          end else begin
            phase_d = PH_EW_GREEN;
          end
        end
        default:      phase_d = PH_ALL_RED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_ALL_RED;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      flash_ph_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      flash_ph_q    <= flash_ph_d;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (phase_q)
      PH_NS_GREEN:  ns_light = LAMP_GRN;
      PH_NS_YELLOW: ns_light = LAMP_YEL;
      PH_EW_GREEN:  ew_light = LAMP_GRN;
      PH_EW_YELLOW: ew_light = LAMP_YEL;
      PH_PED_WALK:  walk     = 1'b1;
      PH_FLASH: begin
        ns_light = flash_ph_q ? LAMP_YEL : LAMP_OFF;
        ew_light = flash_ph_q ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl: a countdown-based phase model is
// compared every cycle, plus literal expectations at the key cycles of each scenario.
module tb_traffic_intersection_ctrl;

  localparam int GREEN  = 10;
  localparam int YELLOW = 5;
  localparam int ALLRED = 2;
  localparam int WALKN  = 8;
  localparam int FHALF  = 4;

  localparam logic [2:0] L_R = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b100;
  localparam logic [2:0] L_O = 3'b000;

  localparam int M_AR = 0, M_NSG = 1, M_NSY = 2, M_EWG = 3, M_EWY = 4, M_WALK = 5, M_FL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       walk, ped_pending;

  int n_checks = 0;
  int n_errors = 0;

  int m_ph = M_AR, m_left = ALLRED;
  bit m_go_ew = 1'b0, m_pend = 1'b0, m_fon = 1'b0;

  traffic_intersection_ctrl #(
    .GREEN_CYC  (GREEN),
    .YELLOW_CYC (YELLOW),
    .ALLRED_CYC (ALLRED),
    .WALK_CYC   (WALKN),
    .FLASH_HALF (FHALF),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .ped_req     (ped_req),
    .flash_mode  (flash_mode),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      M_NSG, M_EWG: return GREEN;
      M_NSY, M_EWY: return YELLOW;
      M_WALK:       return WALKN;
      M_FL:         return FHALF;
      default:      return ALLRED;
    endcase
  endfunction

  // Model: each phase holds a count of remaining enabled ticks.
  always @(posedge clk) begin : model
    int n_ph, n_left;
    bit n_go_ew, n_pend, n_fon;
    n_ph = m_ph; n_left = m_left; n_go_ew = m_go_ew; n_fon = m_fon;
    n_pend = m_pend | ped_req;
    if (rst) begin
      n_ph = M_AR; n_left = ALLRED; n_go_ew = 1'b0; n_pend = 1'b0; n_fon = 1'b0;
    end else if (flash_mode) begin
      if (m_ph != M_FL) begin
        n_ph = M_FL; n_left = FHALF; n_fon = 1'b1;
      end else if (tick_en) begin
        n_left = m_left - 1;
        if (n_left == 0) begin
          n_fon = !m_fon; n_left = FHALF;
        end
      end
    end else if (m_ph == M_FL) begin
      n_ph = M_AR; n_left = ALLRED; n_go_ew = 1'b0;
    end else if (tick_en) begin
      n_left = m_left - 1;
      if (n_left == 0) begin
        case (m_ph)
          M_NSG:  n_ph = M_NSY;
          M_NSY:  begin n_ph = M_AR; n_go_ew = 1'b1; end
          M_EWG:  n_ph = M_EWY;
          M_EWY:  begin n_ph = M_AR; n_go_ew = 1'b0; end
          M_WALK: n_ph = M_AR;
          default: begin
            if (m_pend) begin n_ph = M_WALK; n_pend = ped_req; end
            else n_ph = m_go_ew ? M_EWG : M_NSG;
          end
        endcase
        n_left = dur(n_ph);
      end
    end
    m_ph <= n_ph; m_left <= n_left; m_go_ew <= n_go_ew; m_pend <= n_pend; m_fon <= n_fon;
  end

  task automatic checkModel(input int tid, input int k);
    logic [2:0] ens, eew;
    logic       ew;
    ens = L_R; eew = L_R; ew = 1'b0;
    case (m_ph)
      M_NSG:  ens = L_G;
      M_NSY:  ens = L_Y;
      M_EWG:  eew = L_G;
      M_EWY:  eew = L_Y;
      M_WALK: ew = 1'b1;
      M_FL:   begin ens = m_fon ? L_Y : L_O; eew = ens; end
      default: ;
    endcase
    n_checks++;
    if (ns_light !== ens || ew_light !== eew || walk !== ew || ped_pending !== m_pend) begin
      n_errors++;
      $display("[TB] FAIL model_cmp t%0d k=%0d ns=%b/%b ew=%b/%b walk=%b/%b pend=%b/%b (got/exp)",
               tid, k, ns_light, ens, ew_light, eew, walk, ew, ped_pending, m_pend);
    end
    n_checks++;
    if ($countones(ns_light) > 1 || $countones(ew_light) > 1 ||
        (ns_light != L_R && ew_light != L_R &&
         !(ns_light == ew_light && (ns_light == L_Y || ns_light == L_O))) ||
        (walk && (ns_light != L_R || ew_light != L_R))) begin
      n_errors++;
      $display("[TB] FAIL safety t%0d k=%0d ns=%b ew=%b walk=%b", tid, k, ns_light, ew_light, walk);
    end
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] ens, input logic [2:0] eew,
                             input logic ew, input logic ep);
    n_checks++;
    if (ns_light !== ens || ew_light !== eew || walk !== ew || ped_pending !== ep) begin
      n_errors++;
      $display("[TB] FAIL %s got ns=%b ew=%b walk=%b pend=%b expected ns=%b ew=%b walk=%b pend=%b",
               nm, ns_light, ew_light, walk, ped_pending, ens, eew, ew, ep);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic f, input logic t, input logic r);
    ped_req = p; flash_mode = f; tick_en = t; rst = r;
  endtask

  task automatic literalChecks(input int tid, input int k);
    case (tid)
      1: case (k)
        0:  checkOutput("t1_reset",     L_R, L_R, 0, 0);
        1:  checkOutput("t1_ar_end",    L_R, L_R, 0, 0);
        2:  checkOutput("t1_nsg_start", L_G, L_R, 0, 0);
        11: checkOutput("t1_nsg_end",   L_G, L_R, 0, 0);
        12: checkOutput("t1_nsy_start", L_Y, L_R, 0, 0);
        16: checkOutput("t1_nsy_end",   L_Y, L_R, 0, 0);
        17: checkOutput("t1_ar2",       L_R, L_R, 0, 0);
        19: checkOutput("t1_ewg_start", L_R, L_G, 0, 0);
        28: checkOutput("t1_ewg_end",   L_R, L_G, 0, 0);
        29: checkOutput("t1_ewy_start", L_R, L_Y, 0, 0);
        35: checkOutput("t1_ar3_end",   L_R, L_R, 0, 0);
        36: checkOutput("t1_nsg_again", L_G, L_R, 0, 0);
        default: ;
      endcase
      2: case (k)
        5:  checkOutput("t2_req_cycle", L_G, L_R, 0, 0);
        6:  checkOutput("t2_latched",   L_G, L_R, 0, 1);
        18: checkOutput("t2_ar_pend",   L_R, L_R, 0, 1);
        19: checkOutput("t2_walk_start",L_R, L_R, 1, 0);
        26: checkOutput("t2_walk_end",  L_R, L_R, 1, 0);
        27: checkOutput("t2_ar_after",  L_R, L_R, 0, 0);
        29: checkOutput("t2_ewg",       L_R, L_G, 0, 0);
        default: ;
      endcase
      3: case (k)
        6:  checkOutput("t3_frozen_req",L_G, L_R, 0, 1);
        14: checkOutput("t3_green_13",  L_G, L_R, 0, 1);
        15: checkOutput("t3_nsy",       L_Y, L_R, 0, 1);
        20: checkOutput("t3_ar",        L_R, L_R, 0, 1);
        22: checkOutput("t3_walk",      L_R, L_R, 1, 0);
        32: checkOutput("t3_ewg",       L_R, L_G, 0, 0);
        default: ;
      endcase
      4, 5: case (k)
        7:  checkOutput("t4_pre_flash", L_G, L_R, 0, tid == 5);
        8:  checkOutput("t4_flash_on",  L_Y, L_Y, 0, tid == 5);
        11: checkOutput("t4_on_end",    L_Y, L_Y, 0, tid == 5);
        12: checkOutput("t4_flash_off", L_O, L_O, 0, tid == 5);
        15: checkOutput("t4_off_end",   L_O, L_O, 0, tid == 5);
        16: checkOutput("t4_on_again",  L_Y, L_Y, 0, tid == 5);
        21: checkOutput("t4_exit_ar",   L_R, L_R, 0, tid == 5);
        23: if (tid == 5) checkOutput("t4_walk_after", L_R, L_R, 1, 0);
            else          checkOutput("t4_nsg_after",  L_G, L_R, 0, 0);
        33: if (tid == 5) checkOutput("t4_nsg_post_walk", L_G, L_R, 0, 0);
        default: ;
      endcase
      6: case (k)
        30: checkOutput("t5_pre_rst",   L_R, L_Y, 0, 1);
        31: checkOutput("t5_post_rst",  L_R, L_R, 0, 0);
        33: checkOutput("t5_nsg",       L_G, L_R, 0, 0);
        50: checkOutput("t5_ewg_nowalk",L_R, L_G, 0, 0);
        default: ;
      endcase
      default: ;
    endcase
  endtask

  task automatic runTest(input int tid, input int ncyc);
    logic p, f, t, r;
    applyStimulus(0, 0, 1, 1);
    @(posedge clk); #1;
    for (int k = 0; k < ncyc; k++) begin
      p = 1'b0; f = 1'b0; t = 1'b1; r = 1'b0;
      case (tid)
        2: p = (k == 5);
        3: begin p = (k == 5); t = !(k >= 4 && k <= 6); end
        4, 5: begin f = (k >= 7 && k <= 19); t = (k != 7); p = (tid == 5 && k == 3); end
        6: begin p = (k == 20 || k == 30); r = (k == 30); end
        default: ;
      endcase
      applyStimulus(p, f, t, r);
      @(negedge clk);
      checkModel(tid, k);
      literalChecks(tid, k);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    runTest(1, 37);
    runTest(2, 31);
    runTest(3, 33);
    runTest(4, 34);
    runTest(5, 34);
    runTest(6, 51);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
